// File: rtl/forward_hazard_unit.sv
// Forwarding-select and load-use hazard unit for the five-stage pipeline.
// Forwarding selects are registered for EX; stall/bubble controls are same-cycle.
module forward_hazard_unit #(
    parameter int NUM_SRC  = 2,
    parameter int AW       = 5,
    parameter int LU_STALL = 1,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NUM_SRC*AW-1:0]  RS_ID,
    input  logic [NUM_SRC-1:0]     USE_ID,
    input  logic                   VALID_ID,
    input  logic [AW-1:0]          RD_EX,
    input  logic                   WE_EX,
    input  logic                   LD_EX,
    input  logic [AW-1:0]          RD_MEM,
    input  logic                   WE_MEM,
    input  logic                   HOLD,
    output logic [2*NUM_SRC-1:0]   sFOR,
    output logic                   STALL_ID,
    output logic                   BUBBLE_EX,
    output logic [CNT_W-1:0]       LU_CNT
);

    localparam logic [1:0]       SEL_MEM   = 2'b10;
    localparam logic [1:0]       SEL_WB    = 2'b01;
    localparam logic [1:0]       SEL_RF    = 2'b00;
    localparam logic [1:0]       LU_INIT   = 2'(LU_STALL - 1);
    localparam bit               ZERO_HARD = (ZERO_REG != 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [1:0]             cnt_r;
    logic [1:0]             cnt_nxt_s;
    logic [NUM_SRC-1:0]     m_ex_s;
    logic [NUM_SRC-1:0]     m_mem_s;
    logic [2*NUM_SRC-1:0]   sel_nxt_s;
    logic [2*NUM_SRC-1:0]   for_r;
    logic [CNT_W-1:0]       lu_cnt_r;
    logic                   lu_s;
    logic                   stall_s;

    // Per-slot producer matching and next forwarding select (EX producer is youngest, so it wins)
    always_comb begin
        m_ex_s    = {NUM_SRC{1'b0}};
        m_mem_s   = {NUM_SRC{1'b0}};
        sel_nxt_s = {(2*NUM_SRC){1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            if (VALID_ID && USE_ID[i] &&
                ((RS_ID[i*AW +: AW] != {AW{1'b0}}) || !ZERO_HARD)) begin
                m_ex_s[i]  = WE_EX  && (RD_EX  == RS_ID[i*AW +: AW]);
                m_mem_s[i] = WE_MEM && (RD_MEM == RS_ID[i*AW +: AW]);
            end else begin
                m_ex_s[i]  = 1'b0;
                m_mem_s[i] = 1'b0;
            end
            if (m_ex_s[i]) begin
                sel_nxt_s[2*i +: 2] = SEL_MEM;
            end else if (m_mem_s[i]) begin
                sel_nxt_s[2*i +: 2] = SEL_WB;
            end else begin
                sel_nxt_s[2*i +: 2] = SEL_RF;
            end
        end
    end

    assign lu_s = LD_EX && (|m_ex_s);

    // State and remaining-stall counter register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
            cnt_r   <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic; HOLD freezes both state and counter
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (lu_s && !HOLD && (LU_STALL > 1)) begin
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = LU_INIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!HOLD) begin
                    cnt_nxt_s = cnt_r - 2'd1;
                    if (cnt_r == 2'd1) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 2'd0;
            end
        endcase
    end

    // Stall/bubble outputs, forced low under reset or external freeze
    always_comb begin
        stall_s = 1'b0;
        if (RST || HOLD) begin
            stall_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: stall_s = lu_s;
                ST_WAIT: stall_s = 1'b1;
                default: stall_s = 1'b0;
            endcase
        end
    end

    assign STALL_ID  = stall_s;
    assign BUBBLE_EX = stall_s;

    // Forwarding select register: zeroed when a bubble enters EX
    always_ff @(posedge CLK) begin
        if (RST) begin
            for_r <= {(2*NUM_SRC){1'b0}};
        end else if (HOLD) begin
            for_r <= for_r;
        end else if (stall_s) begin
            for_r <= {(2*NUM_SRC){1'b0}};
        end else begin
            for_r <= sel_nxt_s;
        end
    end

    // Saturating count of load-use sequences, one per IDLE-state hazard
    always_ff @(posedge CLK) begin
        if (RST) begin
            lu_cnt_r <= {CNT_W{1'b0}};
        end else if (!HOLD && (state_r == ST_IDLE) && lu_s && (lu_cnt_r != CNT_MAX)) begin
            lu_cnt_r <= lu_cnt_r + CNT_ONE;
        end else begin
            lu_cnt_r <= lu_cnt_r;
        end
    end

    assign sFOR   = for_r;
    assign LU_CNT = lu_cnt_r;

endmodule
